// File: rtl/alice_sync_pkg.sv
// alice_sync_pkg: shared state encoding, standard field lengths and small helpers
// for the Alice video sync receiver.
`default_nettype none

package alice_sync_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    HLOCK  = 2'd1,
    LOCKED = 2'd2
  } sync_state_t;

  localparam logic [10:0] NTSC_LINES_S = 11'd262;
  localparam logic [10:0] NTSC_LINES_L = 11'd263;
  localparam logic [10:0] PAL_LINES_S  = 11'd312;
  localparam logic [10:0] PAL_LINES_L  = 11'd313;
  localparam logic [8:0]  LONG_LINE    = 9'd228;

  function automatic logic field_len_ok(input logic [10:0] n);
    return (n == NTSC_LINES_S) || (n == NTSC_LINES_L) ||
           (n == PAL_LINES_S)  || (n == PAL_LINES_L);
  endfunction

  function automatic logic [8:0] inc_sat9(input logic [8:0] v);
    return (v == 9'h1FF) ? v : v + 9'd1;
  endfunction

  function automatic logic [10:0] inc_sat11(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alice_sync_rx_fall_det.sv
// sync_fall_det: enable-gated sample flop (resets to 1) with a falling-edge pulse
// that can only fire while the enable is high.
`default_nettype none

module sync_fall_det (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic din,
  output logic fall
);

  logic q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b1;
    end else if (ena) begin
      q <= din;
    end
  end

  assign fall = ena & q & ~din;

endmodule

`default_nettype wire

// File: rtl/alice_sync_rx.sv
// alice_sync_rx: measures line/field timing of Alice HSYNC/VSYNC on CCK ticks and
// tracks lock, PAL/NTSC, interlace and long-line status. Macro: CSYNC_DECODE_EN.
`default_nettype none

module alice_sync_rx
  import alice_sync_pkg::*;
#(
  parameter int unsigned HMIN       = 224,
  parameter int unsigned HMAX       = 232,
  parameter int unsigned LOCK_LINES = 4,
  parameter int unsigned VMAX       = 640,
  parameter int unsigned PAL_THRESH = 288
`ifdef CSYNC_DECODE_EN
  ,
  parameter int unsigned BROAD_W    = 40
`endif
) (
  input  logic        main_clk,
  input  logic        main_rst_n,
  input  logic        cck_ena,
  input  logic        hsync_n,
  input  logic        vsync_n,
`ifdef CSYNC_DECODE_EN
  input  logic        csync_n,
  input  logic        use_csync,
`endif
  output logic [8:0]  hpos,
  output logic [10:0] vpos,
  output logic [8:0]  line_len,
  output logic [10:0] frame_lines,
  output logic        locked,
  output logic        is_pal,
  output logic        is_lace,
  output logic        long_line,
  output logic        sync_err
);

  localparam int unsigned   CW      = $clog2(LOCK_LINES + 1);
  localparam logic [CW-1:0] LOCK_N  = CW'(LOCK_LINES);
  localparam logic [8:0]    HMIN_L  = 9'(HMIN);
  localparam logic [8:0]    HMAX_L  = 9'(HMAX);
  localparam logic [8:0]    HMAX_M1 = 9'(HMAX - 1);
  localparam logic [10:0]   VMAX_M1 = 11'(VMAX - 1);
  localparam logic [10:0]   PAL_L   = 11'(PAL_THRESH);

  sync_state_t   state, state_nxt;
  logic [CW-1:0] lock_cnt, cnt_nxt;
  logic          armed, armed_nxt, err_nxt;
  logic          seen_line;
  logic [10:0]   prev_field;

  logic hs_fall_pin, vs_fall_pin, hs_fall, vs_fall;

  sync_fall_det u_hs_det (
    .clk   (main_clk),
    .rst_n (main_rst_n),
    .ena   (cck_ena),
    .din   (hsync_n),
    .fall  (hs_fall_pin)
  );

  sync_fall_det u_vs_det (
    .clk   (main_clk),
    .rst_n (main_rst_n),
    .ena   (cck_ena),
    .din   (vsync_n),
    .fall  (vs_fall_pin)
  );

`ifdef CSYNC_DECODE_EN
  localparam int unsigned   BW      = $clog2(BROAD_W + 1);
  localparam logic [BW-1:0] BROAD_N = BW'(BROAD_W);
  localparam logic [8:0]    HGATE   = 9'(HMIN - 8);

  logic          cs_fall_pin, cs_hs_fall, cs_vs_fall;
  logic [BW-1:0] cs_low;

  sync_fall_det u_cs_det (
    .clk   (main_clk),
    .rst_n (main_rst_n),
    .ena   (cck_ena),
    .din   (csync_n),
    .fall  (cs_fall_pin)
  );

  // Low-run length; parks at BROAD_N so the broad-pulse strobe fires once per run.
  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      cs_low <= '0;
    end else if (cck_ena) begin
      if (csync_n) begin
        cs_low <= '0;
      end else if (cs_low != BROAD_N) begin
        cs_low <= cs_low + 1'b1;
      end
    end
  end

  // Serration/equalising edges near mid-line must not restart the line.
  assign cs_hs_fall = cs_fall_pin & ((hpos >= HGATE) | (state == SEARCH));
  assign cs_vs_fall = cck_ena & ~csync_n & (cs_low == BROAD_N - 1'b1);
  assign hs_fall    = use_csync ? cs_hs_fall : hs_fall_pin;
  assign vs_fall    = use_csync ? cs_vs_fall : vs_fall_pin;
`else
  assign hs_fall = hs_fall_pin;
  assign vs_fall = vs_fall_pin;
`endif

  logic [8:0]  hpos_inc;
  logic [10:0] vpos_inc, field_len;
  logic        line_ok, field_ok, lace_diff, h_to, v_to;

  assign hpos_inc  = inc_sat9(hpos);
  assign vpos_inc  = inc_sat11(vpos);
  // A line ending on the same tick as the field is counted into that field.
  assign field_len = inc_sat11(hs_fall ? vpos_inc : vpos);
  assign line_ok   = seen_line && (hpos_inc >= HMIN_L) && (hpos_inc <= HMAX_L);
  assign field_ok  = field_len_ok(field_len);
  assign lace_diff = ({1'b0, field_len} == {1'b0, prev_field} + 12'd1) ||
                     ({1'b0, prev_field} == {1'b0, field_len} + 12'd1);
  assign h_to      = cck_ena & ~hs_fall & (hpos == HMAX_M1);
  assign v_to      = hs_fall & ~vs_fall & (vpos == VMAX_M1);

  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      hpos        <= '0;
      vpos        <= '0;
      line_len    <= '0;
      frame_lines <= '0;
      long_line   <= 1'b0;
      is_pal      <= 1'b0;
      is_lace     <= 1'b0;
      prev_field  <= '0;
      seen_line   <= 1'b0;
    end else begin
      if (hs_fall) begin
        hpos      <= '0;
        line_len  <= hpos_inc;
        long_line <= (hpos_inc == LONG_LINE);
        seen_line <= 1'b1;
      end else if (cck_ena) begin
        hpos <= hpos_inc;
      end

      if (vs_fall) begin
        vpos        <= '0;
        frame_lines <= field_len;
        is_pal      <= (field_len >= PAL_L);
        is_lace     <= lace_diff;
        prev_field  <= field_len;
      end else if (hs_fall) begin
        vpos <= vpos_inc;
      end
    end
  end

  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      state    <= SEARCH;
      lock_cnt <= '0;
      armed    <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      lock_cnt <= cnt_nxt;
      armed    <= armed_nxt;
      sync_err <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = lock_cnt;
    armed_nxt = armed;
    err_nxt   = 1'b0;
    unique case (state)
      SEARCH: begin
        if (hs_fall) begin
          if (!line_ok) begin
            cnt_nxt = '0;
          end else if (lock_cnt + 1'b1 == LOCK_N) begin
            state_nxt = HLOCK;
            cnt_nxt   = '0;
            armed_nxt = 1'b0;
          end else begin
            cnt_nxt = lock_cnt + 1'b1;
          end
        end
      end
      HLOCK: begin
        if (h_to || v_to) begin
          state_nxt = SEARCH;
          cnt_nxt   = '0;
        end else if (vs_fall) begin
          if (!armed) begin
            armed_nxt = 1'b1;
          end else if (field_ok) begin
            state_nxt = LOCKED;
          end else begin
            state_nxt = SEARCH;
            cnt_nxt   = '0;
          end
        end
      end
      LOCKED: begin
        if ((hs_fall && !line_ok) || h_to || v_to || (vs_fall && !field_ok)) begin
          state_nxt = SEARCH;
          cnt_nxt   = '0;
          err_nxt   = 1'b1;
        end
      end
      default: begin
        state_nxt = SEARCH;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign locked = (state == LOCKED);

endmodule

`default_nettype wire

// File: tb/tb_alice_sync_rx.sv
// tb_alice_sync_rx: directed bench for alice_sync_rx; CCK ticks every second clock,
// short 6-tick lines are used to build fields quickly outside the LOCKED state.
`timescale 1ns/1ps
`default_nettype none

module tb_alice_sync_rx;

  logic        main_clk   = 1'b0;
  logic        main_rst_n = 1'b0;
  logic        cck_ena    = 1'b0;
  logic        hsync_n    = 1'b1;
  logic        vsync_n    = 1'b1;
`ifdef CSYNC_DECODE_EN
  logic        csync_n    = 1'b1;
  logic        use_csync  = 1'b0;
`endif
  logic [8:0]  hpos, line_len;
  logic [10:0] vpos, frame_lines;
  logic        locked, is_pal, is_lace, long_line, sync_err;

  int n_cmp      = 0;
  int n_bad      = 0;
  int err_cycles = 0;

  alice_sync_rx dut (
    .main_clk    (main_clk),
    .main_rst_n  (main_rst_n),
    .cck_ena     (cck_ena),
    .hsync_n     (hsync_n),
    .vsync_n     (vsync_n),
`ifdef CSYNC_DECODE_EN
    .csync_n     (csync_n),
    .use_csync   (use_csync),
`endif
    .hpos        (hpos),
    .vpos        (vpos),
    .line_len    (line_len),
    .frame_lines (frame_lines),
    .locked      (locked),
    .is_pal      (is_pal),
    .is_lace     (is_lace),
    .long_line   (long_line),
    .sync_err    (sync_err)
  );

  always #5 main_clk = ~main_clk;

  always @(negedge main_clk) if (main_rst_n && sync_err) err_cycles++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic h, input logic v);
    @(negedge main_clk);
    hsync_n = h;
    vsync_n = v;
    cck_ena = 1'b1;
    @(negedge main_clk);
    cck_ena = 1'b0;
  endtask

  // One line: hsync low for the first 4 ticks; vsync low for 3 ticks from vsat (-1 = none).
  task automatic line(input int len, input int vsat);
    for (int i = 0; i < len; i++)
      tick(i >= 4, !(vsat >= 0 && i >= vsat && i < vsat + 3));
  endtask

  task automatic short_lines(input int n);
    for (int i = 0; i < n; i++) line(6, -1);
  endtask

  // npre good lines reach HLOCK, one vsync arms, a 312-line field locks.
  task automatic lock_up(input string tag, input int npre);
    for (int i = 0; i < npre; i++) line(227, -1);
    check({tag, "_hlock_len"}, line_len, 227);
    check({tag, "_hlock_unlocked"}, locked, 0);
    line(227, 100);
    check({tag, "_armed_unlocked"}, locked, 0);
    short_lines(310);
    line(227, 100);
    check({tag, "_locked"}, locked, 1);
    check({tag, "_frame"}, frame_lines, 312);
    check({tag, "_pal"}, is_pal, 1);
  endtask

`ifdef CSYNC_DECODE_EN
  task automatic ctick(input logic c);
    @(negedge main_clk);
    csync_n = c;
    cck_ena = 1'b1;
    @(negedge main_clk);
    cck_ena = 1'b0;
  endtask

  task automatic cline(input int len, input bit serr);
    for (int i = 0; i < len; i++)
      ctick(!(i < 4 || (serr && i >= 113 && i < 116)));
  endtask
`endif

  initial begin
    // Reset state
    repeat (3) @(negedge main_clk);
    check("rst_hpos", hpos, 0);
    check("rst_vpos", vpos, 0);
    check("rst_line_len", line_len, 0);
    check("rst_frame", frame_lines, 0);
    check("rst_flags", {locked, is_pal, is_lace, long_line, sync_err}, 0);
    @(negedge main_clk);
    main_rst_n = 1'b1;

    // PAL interlaced field lengths built from short lines (state stays SEARCH)
    line(6, 2);
    check("first_frame", frame_lines, 2);
    check("first_pal", is_pal, 0);
    short_lines(310);
    line(6, 2);
    check("pal_312", frame_lines, 312);
    check("pal_312_pal", is_pal, 1);
    check("pal_312_lace", is_lace, 0);
    short_lines(311);
    line(6, 2);
    check("pal_313", frame_lines, 313);
    check("pal_313_lace", is_lace, 1);
    short_lines(310);
    line(6, 2);
    check("pal_312b_lace", is_lace, 1);
    check("search_unlocked", locked, 0);

    // Lock onto 227-CCK lines
    lock_up("lock1", 5);
    check("lock1_long", long_line, 0);
    check("lock1_noerr", err_cycles, 0);

    // hsync held high while locked: timeout when hpos reaches 232
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1);
    check("to_pre_hpos", hpos, 231);
    check("to_pre_locked", locked, 1);
    check("to_pre_err", sync_err, 0);
    tick(1'b1, 1'b1);
    check("to_hpos", hpos, 232);
    check("to_locked", locked, 0);
    check("to_err", sync_err, 1);
    @(negedge main_clk);
    check("to_err_drop", sync_err, 0);
    check("to_err_cycles", err_cycles, 1);

    // Relock, then a 200-CCK line while locked
    lock_up("lock2", 5);
    line(227, -1);
    line(227, -1);
    line(200, -1);
    check("pre200_locked", locked, 1);
    line(227, -1);
    check("l200_len", line_len, 200);
    check("l200_locked", locked, 0);
    check("l200_err_cycles", err_cycles, 2);
    lock_up("relock", 4);

    // Alternating 227/228 lines while locked
    line(228, -1);
    check("ll_a", long_line, 0);
    line(227, -1);
    check("ll_b", long_line, 1);
    check("ll_b_len", line_len, 228);
    line(228, -1);
    check("ll_c", long_line, 0);
    line(227, -1);
    check("ll_d", long_line, 1);
    check("ll_locked", locked, 1);
    check("ll_err_cycles", err_cycles, 2);

    // Drop lock with a short line, then coincident hs/vs at vpos=311
    line(6, -1);
    line(6, 2);
    check("drop_locked", locked, 0);
    check("drop_err_cycles", err_cycles, 3);
    short_lines(311);
    check("coin_pre_vpos", vpos, 311);
    line(6, 0);
    check("coin_frame", frame_lines, 313);
    check("coin_vpos", vpos, 0);

    // NTSC non-interlaced 262-line fields
    short_lines(260);
    line(6, 2);
    check("ntsc_frame", frame_lines, 262);
    check("ntsc_pal", is_pal, 0);
    short_lines(260);
    line(6, 2);
    check("ntsc_frame2", frame_lines, 262);
    check("ntsc_lace", is_lace, 0);

    // hsync dip between CCK pulses is ignored
    hsync_n = 1'b0;
    @(posedge main_clk);
    #1 hsync_n = 1'b1;
    tick(1'b1, 1'b1);
    check("gate_hpos", hpos, 6);
    check("gate_len", line_len, 6);

    // Asynchronous reset mid-line
    #2 main_rst_n = 1'b0;
    #1;
    check("arst_hpos", hpos, 0);
    check("arst_len", line_len, 0);
    check("arst_frame", frame_lines, 0);
    @(negedge main_clk);
    main_rst_n = 1'b1;

    // hpos saturates at 511; line_len saturates too
    for (int i = 0; i < 520; i++) tick(1'b1, 1'b1);
    check("sat_hpos", hpos, 511);
    tick(1'b0, 1'b1);
    check("sat_len", line_len, 511);
    check("sat_hpos_clr", hpos, 0);

`ifdef CSYNC_DECODE_EN
    // Composite sync with a serrated line and a broad pulse
    @(negedge main_clk);
    main_rst_n = 1'b0;
    use_csync  = 1'b1;
    @(negedge main_clk);
    main_rst_n = 1'b1;
    for (int i = 0; i < 5; i++) cline(227, 1'b0);
    cline(227, 1'b1);
    cline(227, 1'b0);
    check("cs_len", line_len, 227);
    for (int i = 0; i < 39; i++) ctick(1'b0);
    check("cs_pre_broad", frame_lines, 0);
    ctick(1'b0);
    check("cs_broad_frame", frame_lines, 9);
    check("cs_broad_vpos", vpos, 0);
    check("cs_broad_len", line_len, 227);
    ctick(1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
